// File: rtl/alu.sv
// Single-cycle ALU. Result and flags are computed combinationally from A, B and Op.
// They are registered into Y, C, V and Z on every rising clock edge.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             Z
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    // Every arithmetic op is routed through one adder.
    // Subtraction X-Y becomes X + ~Y + 1, so carry and overflow come from a single rule.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        unique case (Op)
            4'b0000: begin add_x = A;  add_y = WIDTH'(1);          end
            4'b0001: begin add_x = A;  add_y = '1;                 end
            4'b0010: begin add_x = A;  add_y = ~B; add_cin = 1'b1; end
            4'b0011: begin add_x = A;  add_y = B;                  end
            4'b0100: begin add_x = B;  add_y = WIDTH'(1);          end
            4'b0101: begin add_x = B;  add_y = '1;                 end
            4'b0110: begin add_x = '0; add_y = ~A; add_cin = 1'b1; end
            default: begin add_x = '0; add_y = '0;                 end
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (Op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110: begin
                res   = add_sum[WIDTH-1:0];
                res_c = add_sum[WIDTH];
                res_v = add_ovf;
            end
            4'b0111: res = A;
            4'b1000: res = A & B;
            4'b1001: res = A | B;
            4'b1010: res = A ^ B;
            4'b1011: res = ~A;
            4'b1100: begin res = {A[WIDTH-2:0], 1'b0};        res_c = A[WIDTH-1]; end
            4'b1101: begin res = {1'b0, A[WIDTH-1:1]};        res_c = A[0];       end
            4'b1110: begin res = {A[WIDTH-1], A[WIDTH-1:1]};  res_c = A[0];       end
            default: res = B;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= '0;
            C <= 1'b0;
            V <= 1'b0;
            Z <= 1'b0;
        end else begin
            Y <= res;
            C <= res_c;
            V <= res_v;
            Z <= (res == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu.
// It uses a directed vector table, a reset sequence and random ops checked against an arithmetic model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  Op;
    logic [15:0] Y;
    logic        C;
    logic        V;
    logic        Z;

    int vectors;
    int miscompares;

    alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Op(Op),
        .Y(Y), .C(C), .V(V), .Z(Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [15:0] ey, input logic ec,
                         input logic ev, input logic ez);
        vectors++;
        if (Y !== ey || C !== ec || V !== ev || Z !== ez) begin
            miscompares++;
            $display("FAIL %s: got Y=%h C=%b V=%b Z=%b, expected Y=%h C=%b V=%b Z=%b",
                     name, Y, C, V, Z, ey, ec, ev, ez);
        end
    endtask

    // Reference computed from the mathematical rules using wide integer arithmetic.
    function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int          ua, ub, sa, sb, s;
        logic [15:0] y;
        logic        c, v, arith;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        s = 0;
        c = 1'b0;
        arith = 1'b1;
        y = '0;
        case (op)
            4'd0: begin s = sa + 1;  c = (ua + 1) > 65535;  end
            4'd1: begin s = sa - 1;  c = (ua >= 1);         end
            4'd2: begin s = sa - sb; c = (ua >= ub);        end
            4'd3: begin s = sa + sb; c = (ua + ub) > 65535; end
            4'd4: begin s = sb + 1;  c = (ub + 1) > 65535;  end
            4'd5: begin s = sb - 1;  c = (ub >= 1);         end
            4'd6: begin s = -sa;     c = (ua == 0);         end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            y = 16'(s);
            v = (s > 32767) || (s < -32768);
        end else begin
            v = 1'b0;
            case (op)
                4'd7:  y = a;
                4'd8:  y = a & b;
                4'd9:  y = a | b;
                4'd10: y = a ^ b;
                4'd11: y = ~a;
                4'd12: begin y = 16'(ua * 2);  c = (ua >= 32768); end
                4'd13: begin y = 16'(ua / 2);  c = (ua % 2) == 1;  end
                4'd14: begin y = 16'(sa >>> 1); c = (ua % 2) == 1; end
                default: y = b;
            endcase
        end
        return {y, c, v, (y == 16'h0000)};
    endfunction

    initial begin
        logic [18:0] exp;
        vectors = 0;
        miscompares = 0;

        tbl[0]  = '{4'b0000, 16'h0005, 16'h0002, 16'h0006, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 16'h0005, 16'h0002, 16'h0004, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 16'h0005, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'b0011, 16'h0005, 16'h0002, 16'h0007, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'b0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{4'b0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0010, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{4'b0110, 16'h8000, 16'h1234, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'b0110, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{4'b1110, 16'h8001, 16'h0000, 16'hC000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'b1100, 16'h8000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        A = 16'h1234;
        B = 16'h5678;
        Op = 4'b0011;
        repeat (2) @(posedge clk);
        #1 check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            A = tbl[i].a;
            B = tbl[i].b;
            Op = tbl[i].op;
            @(posedge clk);
            #1 check($sformatf("table_%0d", i), tbl[i].y, tbl[i].c, tbl[i].v, tbl[i].z);
        end

        // A nonzero result is loaded first, then reset is asserted between clock edges.
        @(negedge clk);
        A = 16'h0005;
        B = 16'h0002;
        Op = 4'b0011;
        @(posedge clk);
        #1 check("preload", 16'h0007, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        A = 16'h7FFF;
        Op = 4'b0000;
        @(posedge clk);
        #1 check("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #2 check("after_release", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("first_edge", 16'h8000, 1'b0, 1'b1, 1'b0);

        // Changes made between edges must not show until the next edge.
        @(negedge clk);
        A = 16'hFFFF;
        #1 check("no_comb_path", 16'h8000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            Op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: A = 16'h8000;
                1: A = 16'hFFFF;
                2: A = 16'h0000;
                default: A = 16'($urandom);
            endcase
            B = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            exp = model(Op, A, B);
            @(posedge clk);
            #1 check($sformatf("rand_op%0d_a%h_b%h", Op, A, B), exp[18:3], exp[2], exp[1], exp[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
